// File: rtl/hdc_pkg.sv
// Shared constants for the sparse-HDC datapath.
//   HV_DIM          : hypervector width in bits
//   FEATURES_PER_CC : features handled per compute cluster
//   SHIFT_W         : width of one rotation amount
//   SHIFTS          : per-feature rotation table, shared by encoder binder and unbinder
//   hv_t            : hypervector type
package hdc_pkg;

    localparam int HV_DIM          = 1024;
    localparam int FEATURES_PER_CC = 8;
    localparam int SHIFT_W         = $clog2(HV_DIM);

    typedef logic [HV_DIM-1:0] hv_t;

    localparam logic [SHIFT_W-1:0] SHIFTS [0:FEATURES_PER_CC-1] = '{
        10'd0, 10'd1, 10'd3, 10'd7, 10'd13, 10'd29, 10'd61, 10'd127
    };

endpackage

// File: rtl/hv_rotr.sv
// Combinational right-rotator, log2(HV_DIM)-stage barrel shifter.
//   hv     : input vector
//   shamt  : rotate-right amount, must be < HV_DIM
//   hv_out : hv_out[j] = hv[(j + shamt) mod HV_DIM]
module hv_rotr #(
    parameter int HV_DIM  = 1024,
    parameter int SHIFT_W = $clog2(HV_DIM)
) (
    input  logic [HV_DIM-1:0]  hv,
    input  logic [SHIFT_W-1:0] shamt,
    output logic [HV_DIM-1:0]  hv_out
);

    logic [HV_DIM-1:0] stage [0:SHIFT_W];

    assign stage[0] = hv;

    // Stage i rotates by 2**i; since i < clog2(HV_DIM), the amount is always
    // in 1..HV_DIM-1 and the slices below are never empty.
    for (genvar i = 0; i < SHIFT_W; i++) begin : g_stage
        localparam int AMT = 1 << i;
        logic [HV_DIM-1:0] rot;
        assign rot          = {stage[i][AMT-1:0], stage[i][HV_DIM-1:AMT]};
        assign stage[i + 1] = shamt[i] ? rot : stage[i];
    end

    assign hv_out = stage[SHIFT_W];

endmodule

// File: rtl/dec_unbinder_seq.sv
// Sequential unbinder: accepts one bound HV and emits FEATURES_PER_CC
// recovered HVs in index order, HV i = rotr(in, SHIFT_TABLE[i]).
//   clk, nrst            : clock (rising), async active-low reset
//   en                   : global enable, low freezes everything
//   abort                : synchronous return to IDLE
//   in_valid/in_ready/in_hv            : bound HV input stream
//   out_valid/out_ready/out_hv/out_idx/out_last : recovered HV output stream
//   busy                 : high whenever not IDLE
module dec_unbinder_seq #(
    parameter int HV_DIM          = hdc_pkg::HV_DIM,
    parameter int FEATURES_PER_CC = hdc_pkg::FEATURES_PER_CC,
    parameter int SHIFT_W         = $clog2(HV_DIM),
    parameter logic [SHIFT_W-1:0] SHIFT_TABLE [0:FEATURES_PER_CC-1] = hdc_pkg::SHIFTS,
    localparam int IDX_W          = (FEATURES_PER_CC > 1) ? $clog2(FEATURES_PER_CC) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HV_DIM-1:0] in_hv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [HV_DIM-1:0] out_hv,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURES_PER_CC - 1);

    for (genvar g = 0; g < FEATURES_PER_CC; g++) begin : g_shift_chk
        if (int'(SHIFT_TABLE[g]) >= HV_DIM) begin : g_bad
            $error("SHIFT_TABLE[%0d] must be below HV_DIM", g);
        end
    end

    state_t            state, state_d;
    logic [IDX_W-1:0]  cnt, cnt_d;
    logic [HV_DIM-1:0] hv_reg, hv_reg_d;
    logic [HV_DIM-1:0] out_hv_d;
    logic              out_valid_d;
    logic              out_last_d;

    logic [HV_DIM-1:0] rot_src;
    logic [IDX_W-1:0]  rot_idx;
    logic [HV_DIM-1:0] rot_out;

    // One rotator serves both the first output (straight from in_hv) and
    // the following ones (from the held copy), indexed by the next count.
    always_comb begin
        rot_src = hv_reg;
        rot_idx = cnt;
        if (state == IDLE) begin
            rot_src = in_hv;
            rot_idx = '0;
        end else if (cnt != LAST_IDX) begin
            rot_idx = cnt + 1'b1;
        end
    end

    hv_rotr #(
        .HV_DIM  (HV_DIM),
        .SHIFT_W (SHIFT_W)
    ) u_rotr (
        .hv     (rot_src),
        .shamt  (SHIFT_TABLE[rot_idx]),
        .hv_out (rot_out)
    );

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        hv_reg_d    = hv_reg;
        out_hv_d    = out_hv;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        if (abort) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_hv_d    = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_d     = EMIT;
                        hv_reg_d    = in_hv;
                        cnt_d       = '0;
                        out_hv_d    = rot_out;
                        out_valid_d = 1'b1;
                        out_last_d  = (LAST_IDX == '0);
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        if (cnt == LAST_IDX) begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end else begin
                            cnt_d      = cnt + 1'b1;
                            out_hv_d   = rot_out;
                            out_last_d = (cnt + 1'b1 == LAST_IDX);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            hv_reg    <= '0;
            out_hv    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            hv_reg    <= hv_reg_d;
            out_hv    <= out_hv_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
        end
    end

    // in_ready is gated by nrst so it reads 0 for the whole reset pulse.
    assign in_ready = nrst && en && (state == IDLE);
    assign busy     = (state != IDLE);
    assign out_idx  = cnt;

    a_no_ready_busy: assert property (@(posedge clk) disable iff (!nrst)
        !(in_ready && busy));
    a_idx_range: assert property (@(posedge clk) disable iff (!nrst)
        out_idx <= LAST_IDX);
    a_stall_stable: assert property (@(posedge clk) disable iff (!nrst)
        (out_valid && !out_ready && !abort) |=>
        (out_valid && $stable(out_hv) && $stable(out_idx) && $stable(out_last)));

endmodule

// File: doc/dec_unbinder_seq.md
Name: dec_unbinder_seq

Overview:
Sequential unbinder for the sparse-HDC datapath. It is the inverse of the encoder binder stage. It accepts one bound hypervector and emits FEATURES_PER_CC recovered hypervectors, one per feature, in index order. Recovered HV i is the input rotated right by SHIFT_TABLE[i], which undoes the encoder's left rotation by the same amount. It sits between the associative-memory readout and the level-HV similarity/decode logic, with valid/ready streams on both sides.

Parameters:
HV_DIM, 1024, hypervector width in bits.
FEATURES_PER_CC, 8, number of features per compute cluster; equals the number of outputs per accepted HV.
SHIFT_W, $clog2(HV_DIM), width of one shift amount.
SHIFT_TABLE, hdc_pkg::SHIFTS, unpacked array [0:FEATURES_PER_CC-1] of SHIFT_W-bit shift amounts; the same table the encoder binder uses.

Ports:
clk  input  1  clock, rising edge.
nrst  input  1  asynchronous active-low reset.
en  input  1  global enable; when low the block holds all state, accepts nothing and advances nothing.
abort  input  1  synchronous abort; returns the block to IDLE on the next edge.
in_valid  input  1  bound HV available.
in_ready  output  1  block can accept in_hv.
in_hv  input  HV_DIM  bound hypervector.
out_valid  output  1  out_hv/out_idx/out_last are valid.
out_ready  input  1  downstream accepts the current output.
out_hv  output  HV_DIM  recovered level HV for feature out_idx.
out_idx  output  $clog2(FEATURES_PER_CC)  feature index of out_hv.
out_last  output  1  high with the output for feature FEATURES_PER_CC-1.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (nrst=0, asynchronous) forces state=IDLE and cnt=0. Outputs during and after reset: in_ready=0 while nrst=0 and 1 after release; out_valid=0, out_hv=0, out_idx=0, out_last=0, busy=0.
- State IDLE:
  - in_ready = en.
  - An input is accepted when in_valid && in_ready. On acceptance: hv_reg<=in_hv, cnt<=0, state<=EMIT, out_hv<=rotr(in_hv, SHIFT_TABLE[0]), out_idx<=0, out_valid<=1.
  - Latency: first output is valid exactly 1 cycle after acceptance.
- State EMIT:
  - in_ready=0.
  - A beat transfers when out_valid && out_ready && en.
  - On a transfer with cnt<F-1: cnt++, and out_hv/out_idx update to the next feature on the same edge. Back-to-back throughput is one output per cycle.
  - On a transfer with cnt==F-1: out_valid<=0, state<=IDLE. The new in_ready is visible the following cycle, so there is one bubble between input HVs.
  - out_hv, out_idx and out_last stay stable while out_valid && !out_ready (stream stall rule).
  - en=0 freezes all registers, including during a stall. out_valid stays at its current value.
- out_last = out_valid && (out_idx==F-1). It is registered together with out_idx.
- Rotation:
  - rotr(x,s)[j] = x[(j+s) mod HV_DIM].
  - s=0 passes x through; s values >= HV_DIM are illegal and must be caught by an elaboration check on SHIFT_TABLE.
  - Purely combinational on hv_reg and SHIFT_TABLE[next_cnt]; the result is registered into out_hv.
- abort=1 at an edge (while nrst=1):
  - state<=IDLE, out_valid<=0, cnt<=0, out_hv<=0.
  - abort takes priority over acceptance and transfer in the same cycle; no input is accepted that cycle.
- nrst deasserted mid-EMIT: immediate return to reset values; the partial sequence is discarded and never resumed.
- FEATURES_PER_CC=1: every accepted HV yields exactly one output with out_last=1.
- Assertions:
  - No in_ready while busy.
  - out_idx never exceeds F-1.
  - Stall stability of the out_* signals.

Decomposition:
- hdc_pkg holds HV_DIM, FEATURES_PER_CC, the SHIFTS table shared with the encoder binder, and typedef hv_t = logic [HV_DIM-1:0].
- The state enum {IDLE, EMIT} is local to this module.
- One sub-module, hv_rotr: a combinational right-rotator with parameter HV_DIM, inputs hv and shamt, output hv_out. It is implemented as a log2(HV_DIM)-stage barrel shifter.

Test Plan:
Bench configuration for all scenarios: HV_DIM=16, F=4, SHIFT_TABLE={0,1,5,15}.
1. Basic sequence: in_hv=16'h0001 accepted, out_ready=1 -> outputs 0001, 8000, 0800, 0002 on 4 consecutive cycles with idx 0..3; out_last only on idx 3; in_ready returns 1 cycle after the last transfer.
2. Round-trip with encoder: encoder-bind a random sparse HV x with shift 5, feed the result in -> out_hv at idx 2 equals x exactly; repeat for 1000 random x.
3. Backpressure: out_ready toggled 1,0,0,1,0,1,1 -> every out_* value holds through each stall; the four outputs are in order with no loss or duplication.
4. en low mid-EMIT at idx 1 for 3 cycles with out_ready=1 -> no advance and idx stays 1; the sequence resumes at idx 1 when en returns high.
5. abort at idx 2 with in_valid=1 held -> next cycle IDLE, out_valid=0, out_hv=0; the input is accepted the cycle after that, and its sequence restarts at idx 0.
6. Async reset: nrst pulsed low mid-cycle during EMIT -> out_valid=0 and busy=0 immediately, with no clock edge needed; no output from the aborted HV appears after release.
